// File: rtl/riscv_result_capture.sv
// riscv_result_capture: run monitor downstream of the RISC-V core.
// Counts cycles, captures s1 on the s2 sentinel, presents it once.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   s1         in   result register tap (WIDTH)
//   s2         in   status register tap (WIDTH)
//   res_ready  in   consumer accepts the result
//   res_valid  out  result available
//   res_data   out  latched s1 (WIDTH)
//   res_cycles out  latched cycle count (CNT_W)
//   res_status out  00 none, 01 done, 10 timeout
//   cpu_halt   out  sticky hold request to the core
//   busy       out  high while running
//
// Optional watchdog: define RESULT_TIMEOUT_EN.
module riscv_result_capture #(
  parameter int unsigned          WIDTH          = 32,
  parameter int unsigned          CNT_W          = 16,
  parameter logic [WIDTH-1:0]     SENTINEL       = 32'hFFFF_FFFF,
  parameter int unsigned          TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] res_cycles,
  output logic [1:0]       res_status,
  output logic             cpu_halt,
  output logic             busy
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_DONE = 2'b01;
`ifdef RESULT_TIMEOUT_EN
  localparam logic [1:0] ST_TOUT = 2'b10;
`endif

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cycles_q;
  logic [1:0]       status_q;
  logic             halt_q;

  // Count this edge would record; pinned at all ones.
  logic [CNT_W-1:0] cnt_d;
  logic             sent_hit;

  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign sent_hit = (s2 == SENTINEL);

`ifdef RESULT_TIMEOUT_EN
  // Compared at 32 bits so a limit beyond the counter range
  // simply never fires instead of aliasing.
  logic to_hit;
  assign to_hit = (32'(cnt_d) == 32'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      cycles_q <= '0;
      status_q <= ST_NONE;
      halt_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          cnt_q <= cnt_d;
          if (sent_hit) begin
            state_q  <= PRESENT;
            data_q   <= s1;
            cycles_q <= cnt_d;
            status_q <= ST_DONE;
            valid_q  <= 1'b1;
            halt_q   <= 1'b1;
          end
`ifdef RESULT_TIMEOUT_EN
          else if (to_hit) begin
            state_q  <= PRESENT;
            data_q   <= s1;
            cycles_q <= cnt_d;
            status_q <= ST_TOUT;
            valid_q  <= 1'b1;
            halt_q   <= 1'b1;
          end
`endif
        end
        PRESENT: begin
          if (valid_q && res_ready) begin
            state_q <= DONE;
            valid_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= DONE;
          valid_q <= 1'b0;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  assign res_valid  = valid_q;
  assign res_data   = data_q;
  assign res_cycles = cycles_q;
  assign res_status = status_q;
  assign cpu_halt   = halt_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_riscv_result_capture.sv
// tb_riscv_result_capture: directed bench for riscv_result_capture.
// Inputs driven at falling edges, outputs sampled there too.
module tb_riscv_result_capture;

  logic        clk;
  logic        reset;
  logic [31:0] s1, s2;
  logic        rdy;
  logic        vld;
  logic [31:0] data;
  logic [15:0] cyc;
  logic [1:0]  st;
  logic        halt;
  logic        busy;

  logic        rst8;
  logic [31:0] s1b, s2b;
  logic        rdyb;
  logic        vldb;
  logic [31:0] datab;
  logic [7:0]  cycb;
  logic [1:0]  stb;
  logic        haltb;
  logic        busyb;

  int checks;
  int failures;

  riscv_result_capture #(
    .WIDTH(32), .CNT_W(16),
    .SENTINEL(32'hFFFF_FFFF), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .s1(s1), .s2(s2),
    .res_ready(rdy), .res_valid(vld), .res_data(data),
    .res_cycles(cyc), .res_status(st), .cpu_halt(halt),
    .busy(busy)
  );

  riscv_result_capture #(
    .WIDTH(32), .CNT_W(8),
    .SENTINEL(32'hFFFF_FFFF), .TIMEOUT_CYCLES(1000)
  ) dut8 (
    .clk(clk), .reset(rst8), .s1(s1b), .s2(s2b),
    .res_ready(rdyb), .res_valid(vldb), .res_data(datab),
    .res_cycles(cycb), .res_status(stb), .cpu_halt(haltb),
    .busy(busyb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    s1    = '0;
    s2    = '0;
    rdy   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b0; s1 = '0; s2 = '0; rdy = 1'b0;
    rst8  = 1'b0; s1b = '0; s2b = '0; rdyb = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_valid",  32'(vld),  0);
    chk("rst_data",   data,      0);
    chk("rst_cycles", 32'(cyc),  0);
    chk("rst_status", 32'(st),   0);
    chk("rst_halt",   32'(halt), 0);
    chk("rst_busy",   32'(busy), 1);
    reset = 1'b1;

    // 1: sentinel before edge 10, ready high
    edges(9);
    chk("t1_pre_valid", 32'(vld), 0);
    s1 = 32'd55; s2 = 32'hFFFF_FFFF; rdy = 1'b1;
    edges(1);
    chk("t1_valid",  32'(vld),  1);
    chk("t1_data",   data,      32'd55);
    chk("t1_cycles", 32'(cyc),  32'd10);
    chk("t1_status", 32'(st),   32'd1);
    chk("t1_halt",   32'(halt), 1);
    chk("t1_busy",   32'(busy), 0);
    edges(1);
    chk("t1_drop",   32'(vld),  0);
    chk("t1_halt2",  32'(halt), 1);

    // 6: activity after DONE is ignored
    s1 = 32'd99; s2 = 32'hFFFF_FFFF;
    edges(3);
    chk("t6_data",   data,      32'd55);
    chk("t6_valid",  32'(vld),  0);
    chk("t6_cycles", 32'(cyc),  32'd10);
    chk("t6_halt",   32'(halt), 1);

    // 2: back-pressure for 5 cycles
    do_reset();
    edges(3);
    s1 = 32'h1234; s2 = 32'hFFFF_FFFF;
    edges(1);
    chk("t2_valid",  32'(vld), 1);
    chk("t2_cycles", 32'(cyc), 32'd4);
    s1 = 32'hBEEF; s2 = '0;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      chk("t2_hold_valid",  32'(vld), 1);
      chk("t2_hold_data",   data,     32'h1234);
      chk("t2_hold_cycles", 32'(cyc), 32'd4);
      chk("t2_hold_status", 32'(st),  32'd1);
    end
    rdy = 1'b1;
    edges(1);
    chk("t2_accept_valid", 32'(vld),  0);
    chk("t2_accept_halt",  32'(halt), 1);

    // 3: sentinel pulse between edges
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1 s2 = 32'hFFFF_FFFF;
      #2 s2 = '0;
      @(negedge clk);
    end
    chk("t3_busy",   32'(busy), 1);
    chk("t3_valid",  32'(vld),  0);
    chk("t3_status", 32'(st),   0);
    chk("t3_halt",   32'(halt), 0);

    // 4: async reset in PRESENT
    do_reset();
    edges(1);
    s1 = 32'hA5; s2 = 32'hFFFF_FFFF;
    edges(1);
    chk("t4_present", 32'(vld), 1);
    s2 = '0;
    #2 reset = 1'b0;
    #1;
    chk("t4_valid",  32'(vld),  0);
    chk("t4_data",   data,      0);
    chk("t4_cycles", 32'(cyc),  0);
    chk("t4_status", 32'(st),   0);
    chk("t4_halt",   32'(halt), 0);
    @(negedge clk);
    reset = 1'b1;
    edges(2);
    s1 = 32'h3C; s2 = 32'hFFFF_FFFF;
    edges(1);
    chk("t4_cycles3", 32'(cyc), 32'd3);
    chk("t4_data3",   data,     32'h3C);

    // 5: watchdog / no sentinel
    do_reset();
    edges(19);
    chk("t5_pre_valid", 32'(vld), 0);
    edges(1);
`ifdef RESULT_TIMEOUT_EN
    chk("t5_to_valid",  32'(vld),  1);
    chk("t5_to_status", 32'(st),   32'd2);
    chk("t5_to_cycles", 32'(cyc),  32'd20);
    chk("t5_to_halt",   32'(halt), 1);
`else
    chk("t5_nc_valid",  32'(vld),  0);
    chk("t5_nc_busy",   32'(busy), 1);
    chk("t5_nc_status", 32'(st),   0);
`endif

    // 5b: 8-bit counter saturation
    rst8 = 1'b1;
    edges(299);
    chk("t5b_valid", 32'(vldb),  0);
    chk("t5b_busy",  32'(busyb), 1);
    s1b = 32'd7; s2b = 32'hFFFF_FFFF;
    edges(1);
    chk("t5b_cap",    32'(vldb), 1);
    chk("t5b_cycles", 32'(cycb), 32'hFF);
    chk("t5b_status", 32'(stb),  32'd1);
    chk("t5b_data",   datab,     32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
